// File: rtl/plru_repl_ctrl_pkg.sv
// Shared definitions for the 4-way tree-PLRU replacement controller:
// op encodings, FSM states, tree bit positions and the tree helper functions.
package plru_repl_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_TOUCH     = 2'b00,
        OP_ALLOC     = 2'b01,
        OP_INVAL     = 2'b10,
        OP_CLEAR_ALL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP,
        ST_CLEAR
    } state_e;

    // Tree bits: A is the root, B arbitrates ways 0/1, C arbitrates ways 2/3.
    localparam int TREE_A = 2;
    localparam int TREE_B = 1;
    localparam int TREE_C = 0;

    typedef logic [2:0] tree_t;
    typedef logic [3:0] valid_t;

    // Way the tree currently points at as least recently used.
    function automatic logic [1:0] tree_victim(input tree_t t);
        if (!t[TREE_A]) begin
            return t[TREE_B] ? 2'd1 : 2'd0;
        end
        return t[TREE_C] ? 2'd3 : 2'd2;
    endfunction

    // Point the tree away from way w; the bit on the other subtree is kept.
    function automatic tree_t tree_update(input tree_t t, input logic [1:0] w);
        tree_t n;
        n = t;
        case (w)
            2'd0: begin n[TREE_A] = 1'b1; n[TREE_B] = 1'b1; end
            2'd1: begin n[TREE_A] = 1'b1; n[TREE_B] = 1'b0; end
            2'd2: begin n[TREE_A] = 1'b0; n[TREE_C] = 1'b1; end
            default: begin n[TREE_A] = 1'b0; n[TREE_C] = 1'b0; end
        endcase
        return n;
    endfunction

    // Lowest-numbered way whose valid bit is clear (0 when all are valid).
    function automatic logic [1:0] first_invalid(input valid_t v);
        logic [1:0] w;
        w = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) w = 2'(i);
        end
        return w;
    endfunction

endpackage

// File: rtl/plru_repl_ctrl_if.sv
// Request/response bus of the PLRU replacement controller.
interface plru_repl_ctrl_if #(
    parameter int IDX_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [IDX_W-1:0] req_index;
    logic [1:0]       req_way;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_way;
    logic             rsp_fill;

    modport master (
        output req_valid, req_op, req_index, req_way, rsp_ready,
        input  req_ready, rsp_valid, rsp_way, rsp_fill
    );

    modport slave (
        input  req_valid, req_op, req_index, req_way, rsp_ready,
        output req_ready, rsp_valid, rsp_way, rsp_fill
    );
endinterface

// File: rtl/plru_tree4.sv
// Combinational 4-way PLRU tree: victim lookup and update for a given way.
module plru_tree4
    import plru_repl_ctrl_pkg::*;
(
    input  tree_t      tree_in,
    input  logic [1:0] upd_way,
    output tree_t      tree_out,
    output logic [1:0] victim
);
    assign tree_out = tree_update(tree_in, upd_way);
    assign victim   = tree_victim(tree_in);
endmodule

// File: rtl/plru_repl_ctrl.sv
// Tree-PLRU replacement controller: per-set 3-bit tree plus 4 valid bits,
// serviced one request at a time through IDLE/EXEC/RESP/CLEAR.
module plru_repl_ctrl
    import plru_repl_ctrl_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
)(
    input logic              clk,
    input logic              rst,
    plru_repl_ctrl_if.slave  bus
);
    state_e           state;
    op_e              op_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       way_q;
    logic [IDX_W-1:0] clr_cnt;
    logic             ready_q;
    logic             rsp_valid_q;
    logic [1:0]       rsp_way_q;
    logic             rsp_fill_q;

    tree_t  tree_mem  [SETS];
    valid_t valid_mem [SETS];

    tree_t      cur_tree;
    valid_t     cur_valid;
    tree_t      upd_tree;
    logic [1:0] victim;
    logic [1:0] chosen_way;
    logic       chosen_fill;
    valid_t     next_valid;
    tree_t      next_tree;

    assign cur_tree  = tree_mem[idx_q];
    assign cur_valid = valid_mem[idx_q];

    plru_tree4 u_tree (
        .tree_in  (cur_tree),
        .upd_way  (chosen_way),
        .tree_out (upd_tree),
        .victim   (victim)
    );

    // Per-op choice of way, fill flag and new set state for the EXEC cycle.
    always_comb begin
        chosen_way  = way_q;
        chosen_fill = 1'b0;
        next_valid  = cur_valid;
        next_tree   = upd_tree;
        case (op_q)
            OP_ALLOC: begin
                if (!(&cur_valid)) begin
                    chosen_way  = first_invalid(cur_valid);
                    chosen_fill = 1'b1;
                end else begin
                    chosen_way  = victim;
                end
                next_valid[chosen_way] = 1'b1;
            end
            OP_INVAL: begin
                next_valid[way_q] = 1'b0;
                next_tree         = cur_tree;
            end
            default: ;
        endcase
    end

    // Controller FSM with registered outputs and set-state write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= OP_TOUCH;
            idx_q       <= '0;
            way_q       <= 2'd0;
            clr_cnt     <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_way_q   <= 2'd0;
            rsp_fill_q  <= 1'b0;
            // NOTE: the set state array is reset here on purpose: replacement
            // must start from a known tree and all-invalid after reset, so it
            // is built from flops, not an uninitialised RAM.
            for (int i = 0; i < SETS; i++) begin
                tree_mem[i]  <= '0;
                valid_mem[i] <= '0;
            end
        end else begin
            // NOTE: every register in this block uses <=, so all reads see
            // the pre-edge values regardless of statement order.
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        op_q    <= op_e'(bus.req_op);
                        idx_q   <= bus.req_index;
                        way_q   <= bus.req_way;
                        clr_cnt <= '0;
                        ready_q <= 1'b0;
                        state   <= (op_e'(bus.req_op) == OP_CLEAR_ALL) ? ST_CLEAR : ST_EXEC;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    tree_mem[idx_q]  <= next_tree;
                    valid_mem[idx_q] <= next_valid;
                    rsp_way_q        <= chosen_way;
                    rsp_fill_q       <= chosen_fill;
                    rsp_valid_q      <= 1'b1;
                    state            <= ST_RESP;
                end
                ST_CLEAR: begin
                    tree_mem[clr_cnt]  <= '0;
                    valid_mem[clr_cnt] <= '0;
                    if (clr_cnt == IDX_W'(SETS - 1)) begin
                        rsp_way_q   <= 2'd0;
                        rsp_fill_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        clr_cnt <= clr_cnt + IDX_W'(1);
                    end
                end
                default: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_way   = rsp_way_q;
    assign bus.rsp_fill  = rsp_fill_q;

endmodule

// File: tb/tb_plru_repl_ctrl.sv
// Self-checking bench for plru_repl_ctrl: directed scenarios plus randomized
// traffic against a recency-based model of 4-way tree PLRU.
module tb_plru_repl_ctrl;
    localparam int SETS  = 16;
    localparam int IDX_W = 4;
    localparam logic [1:0] TOUCH = 2'b00, ALLOC = 2'b01, INVAL = 2'b10, CLR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    plru_repl_ctrl_if #(.IDX_W(IDX_W)) bus ();

    plru_repl_ctrl #(.SETS(SETS), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: which half was used most recently, and which way inside each
    // pair was used most recently. The victim is the older half, then the
    // older way of that pair. Valid bits kept per way.
    bit m_valid     [SETS][4];
    bit m_last_half [SETS];
    bit m_last_pair [SETS][2];

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
            m_last_half[s]    = 1'b1; // victim starts in the left pair
            m_last_pair[s][0] = 1'b1; // victim of left pair is way 0
            m_last_pair[s][1] = 1'b1; // victim of right pair is way 2
        end
    endtask

    task automatic model_use(input int s, input int w);
        m_last_half[s] = (w >= 2);
        m_last_pair[s][w / 2] = (w % 2 == 1);
    endtask

    task automatic model_op(input logic [1:0] op, input int s, input int w,
                            output logic [1:0] ew, output logic ef);
        int pick;
        ew = 2'd0;
        ef = 1'b0;
        case (op)
            TOUCH: begin model_use(s, w); ew = 2'(w); end
            INVAL: begin m_valid[s][w] = 1'b0; ew = 2'(w); end
            ALLOC: begin
                pick = -1;
                for (int i = 0; i < 4; i++)
                    if (pick < 0 && !m_valid[s][i]) pick = i;
                if (pick >= 0) begin
                    ef = 1'b1;
                end else begin
                    pick = (m_last_half[s] ? 0 : 2) + (m_last_pair[s][m_last_half[s] ? 0 : 1] ? 0 : 1);
                end
                model_use(s, pick);
                m_valid[s][pick] = 1'b1;
                ew = 2'(pick);
            end
            default: model_reset();
        endcase
    endtask

    // Present a request and return once it has been accepted (#1 after the edge).
    task automatic send_req(input logic [1:0] op, input int idx, input int w, output bit ok);
        int guard = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_index = IDX_W'(idx);
        bus.req_way   = 2'(w);
        while (bus.req_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        ok = (guard < 100);
        if (ok) begin
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] op, input int idx, input int w, input int hold,
                          output logic [1:0] rway, output logic rfill, output int lat);
        bit ok;
        rway = 2'd0; rfill = 1'b0; lat = 0;
        send_req(op, idx, w, ok);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready never high (op %0d set %0d)", op, idx);
            return;
        end
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        if (bus.rsp_valid !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout: no rsp_valid after %0d cycles (op %0d)", lat, op);
            return;
        end
        rway  = bus.rsp_way;
        rfill = bus.rsp_fill;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_way !== rway || bus.rsp_fill !== rfill || bus.req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_stable: cyc %0d valid=%b way=%0d fill=%b ready=%b, need 1/%0d/%b/0",
                         i, bus.rsp_valid, bus.rsp_way, bus.rsp_fill, bus.req_ready, rway, rfill);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    // One operation checked against the model, including its latency.
    task automatic run_op(input logic [1:0] op, input int idx, input int w, input int hold,
                          input string tag, output logic [1:0] rway, output logic rfill);
        logic [1:0] ew;
        logic       ef;
        int         lat;
        int         elat;
        model_op(op, idx, w, ew, ef);
        do_req(op, idx, w, hold, rway, rfill, lat);
        n_cmp++;
        if (rway !== ew || rfill !== ef) begin
            n_bad++;
            $display("FAIL %s: set %0d op %0d got way %0d fill %b, need way %0d fill %b",
                     tag, idx, op, rway, rfill, ew, ef);
        end
        elat = (op == CLR) ? SETS + 1 : 2;
        n_cmp++;
        if (lat != elat) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d cycles, need %0d", tag, lat, elat);
        end
    endtask

    task automatic apply_reset();
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_index = '0;
        bus.req_way = 2'd0; bus.rsp_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_way !== 2'd0 || bus.rsp_fill !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: ready=%b valid=%b way=%0d fill=%b, need 0/0/0/0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_way, bus.rsp_fill);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: req_ready=%b after first clock, need 1", bus.req_ready);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_fill_order();
        logic [1:0] rw; logic rf;
        logic [1:0] exp_w [5];
        logic       exp_f [5];
        exp_w = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_f = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            run_op(ALLOC, 3, 0, 0, "fill_order", rw, rf);
            n_cmp++;
            if (rw !== exp_w[i] || rf !== exp_f[i]) begin
                n_bad++;
                $display("FAIL fill_order_abs[%0d]: got %0d/%b need %0d/%b", i, rw, rf, exp_w[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_touch_victim();
        logic [1:0] rw; logic rf;
        for (int i = 0; i < 4; i++) run_op(ALLOC, 5, 0, 0, "touch_fill", rw, rf);
        run_op(TOUCH, 5, 0, 0, "touch0", rw, rf);
        run_op(TOUCH, 5, 2, 0, "touch2", rw, rf);
        run_op(ALLOC, 5, 0, 0, "touch_victim", rw, rf);
        n_cmp++;
        if (rw !== 2'd1 || rf !== 1'b0) begin
            n_bad++;
            $display("FAIL touch_victim_abs: got %0d/%b need 1/0", rw, rf);
        end
    endtask

    task automatic test_inval_refill();
        logic [1:0] rw; logic rf;
        for (int i = 0; i < 4; i++) run_op(ALLOC, 7, 0, 0, "inval_fill", rw, rf);
        run_op(INVAL, 7, 2, 0, "inval2", rw, rf);
        run_op(ALLOC, 7, 0, 0, "inval_refill", rw, rf);
        n_cmp++;
        if (rw !== 2'd2 || rf !== 1'b1) begin
            n_bad++;
            $display("FAIL inval_refill_abs: got %0d/%b need 2/1", rw, rf);
        end
    endtask

    task automatic test_hold();
        logic [1:0] rw; logic rf;
        run_op(TOUCH, 9, 3, 5, "hold_touch", rw, rf);
        run_op(ALLOC, 9, 0, 5, "hold_alloc", rw, rf);
    endtask

    task automatic test_clear_all();
        logic [1:0] rw; logic rf;
        for (int s = 0; s < SETS; s += 3)
            for (int i = 0; i < 3; i++) run_op(ALLOC, s, 0, 0, "pre_clear", rw, rf);
        run_op(CLR, 0, 0, 0, "clear_all", rw, rf);
        for (int s = 0; s < SETS; s++) begin
            run_op(ALLOC, s, 0, 0, "post_clear", rw, rf);
            n_cmp++;
            if (rw !== 2'd0 || rf !== 1'b1) begin
                n_bad++;
                $display("FAIL post_clear_abs: set %0d got %0d/%b need 0/1", s, rw, rf);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [1:0] rw; logic rf;
        bit ok;
        for (int i = 0; i < 4; i++) run_op(ALLOC, 10, 0, 0, "pre_rst", rw, rf);
        run_op(TOUCH, 10, 1, 0, "pre_rst_touch", rw, rf);
        send_req(CLR, 0, 0, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL mid_clear_accept: CLEAR_ALL not accepted");
        end
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_clear_in_rst: valid=%b ready=%b need 0/0", bus.rsp_valid, bus.req_ready);
            end
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < SETS + 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_clear_no_rsp: rsp_valid=%b at cycle %0d, need 0", bus.rsp_valid, i);
            end
        end
        bus.rsp_ready = 1'b0;
        for (int s = 0; s < SETS; s++) run_op(ALLOC, s, 0, 0, "after_rst", rw, rf);
        for (int i = 0; i < 4; i++) run_op(ALLOC, 10, 0, 0, "after_rst_tree", rw, rf);
    endtask

    task automatic test_random();
        logic [1:0] rw; logic rf;
        logic [1:0] op;
        int r;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 5) ? ALLOC : (r < 8) ? TOUCH : INVAL;
            run_op(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "random", rw, rf);
        end
    endtask

    initial begin
        test_reset();
        test_fill_order();
        test_touch_victim();
        test_inval_refill();
        test_hold();
        test_clear_all();
        test_reset_mid_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
